// File: rtl/nibble_chain_add_ctrl.sv
// Sequences a wide addition through an external 4-bit adder, one nibble per clock, LSB first.
// Operands arrive and results leave over independent valid/ready handshakes.
module nibble_chain_add_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [4*NIBBLES-1:0] in_a_i,
  input  logic [4*NIBBLES-1:0] in_b_i,
  input  logic                 in_cin_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [4*NIBBLES-1:0] out_sum_o,
  output logic                 out_cout_o,
  output logic                 out_ovf_o,
  output logic [3:0]           add_a_o,
  output logic [3:0]           add_b_o,
  output logic                 add_cin_o,
  output logic                 add_enable_o,
  input  logic [3:0]           add_sum_i,
  input  logic                 add_cout_i
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [W-1:0]    op_a_q, op_a_d;
  logic [W-1:0]    op_b_q, op_b_d;
  logic            cin_q, cin_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    cin_d        = cin_q;
    carry_d      = carry_q;
    sum_d        = sum_q;
    cout_d       = cout_q;
    ovf_d        = ovf_q;
    in_ready_o   = 1'b0;
    out_valid_o  = 1'b0;
    add_a_o      = 4'h0;
    add_b_o      = 4'h0;
    add_cin_o    = 1'b0;
    add_enable_o = 1'b1;

    unique case (state_q)
      StIdle: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          op_a_d  = in_a_i;
          op_b_d  = in_b_i;
          cin_d   = in_cin_i;
          idx_d   = '0;
          state_d = StRun;
        end
      end

      StRun: begin
        add_enable_o = 1'b0;
        add_cin_o    = (idx_q == '0) ? cin_q : carry_q;
        // Decode the slice index explicitly so every select is constant.
        for (int unsigned i = 0; i < NIBBLES; i++) begin
          if (idx_q == IdxW'(i)) begin
            add_a_o          = op_a_q[4*i +: 4];
            add_b_o          = op_b_q[4*i +: 4];
            sum_d[4*i +: 4]  = add_sum_i;
          end
        end
        carry_d = add_cout_i;
        if (idx_q == LastIdx) begin
          cout_d  = add_cout_i;
          ovf_d   = (op_a_q[W-1] == op_b_q[W-1]) && (add_sum_i[3] != op_a_q[W-1]);
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      StDone: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    if (rst_i) begin
      in_ready_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_sum_o  = sum_q;
  assign out_cout_o = cout_q;
  assign out_ovf_o  = ovf_q;

endmodule

// File: doc/nibble_chain_add_ctrl.md
# nibble_chain_add_ctrl

Sequencing controller that drives the team's 4-bit parallel-carry adder with enable, one nibble per clock, to produce wide additions. It accepts a wide operand pair over a valid/ready handshake. Each cycle it presents one nibble slice plus the chained carry to the adder and captures the adder's combinational sum/cout. It then delivers the assembled result, carry and signed overflow over a second valid/ready handshake.

## Interface
Parameters:
- NIBBLES, 4, number of 4-bit slices; operand/result width W = 4*NIBBLES (NIBBLES ≥ 2)

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair offered
- in_ready  output  1  controller can accept operands
- in_a  input  W  operand A
- in_b  input  W  operand B
- in_cin  input  1  carry into nibble 0
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- out_sum  output  W  registered sum
- out_cout  output  1  carry out of MSB nibble
- out_ovf  output  1  two's-complement overflow
- add_a  output  4  to adder operand a
- add_b  output  4  to adder operand b
- add_cin  output  1  to adder cin
- add_enable  output  1  to adder enable; 0 = adder drives sum, 1 = adder sum is high-Z
- add_sum  input  4  from adder sum
- add_cout  input  1  from adder cout

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, register in_a, in_b and in_cin. Clear idx to 0 and go to RUN.
- RUN drives the adder combinationally from registered state:
  - add_a = op_a[4*idx+3:4*idx]
  - add_b = op_b[4*idx+3:4*idx]
  - add_cin = (idx==0) ? cin_reg : carry_reg
  - add_enable=0
- RUN edge actions:
  - Write add_sum into the result nibble idx.
  - carry_reg ← add_cout.
  - idx ← idx+1.
- RUN exit: when idx==NIBBLES-1, also load out_cout ← add_cout and compute out_ovf. Then go to DONE.
- out_ovf = (op_a[W-1]==op_b[W-1]) && (add_sum[3] != op_a[W-1]), evaluated in the last RUN cycle.
- Outside RUN: add_a=0, add_b=0, add_cin=0, add_enable=1. Never sample add_sum outside RUN, because it is high-Z there.
- DONE: out_valid=1; out_sum, out_cout and out_ovf hold stable. On out_valid&out_ready, go to IDLE. Result registers keep their value until overwritten.
- in_ready=0 in RUN and DONE. in_valid is ignored there, and the operand registers do not change.
- The DONE-to-IDLE handshake cycle does not accept new operands. Earliest accept is the following cycle.
- idx width is clog2(NIBBLES). It never wraps past NIBBLES-1.

## Timing
- Reset (rst=1 at an edge):
  - state=IDLE; idx=0; carry_reg=0.
  - out_sum=0, out_cout=0, out_ovf=0, out_valid=0.
  - add_enable=1.
  - in_ready is forced 0 while rst is high and becomes 1 the first cycle after reset is released.
- Reset mid-RUN or mid-DONE abandons the operation. The next cycle is IDLE with all outputs at their reset values. No partial result escapes.
- Accept at edge T0. RUN occupies cycles T0+1 … T0+NIBBLES, one nibble per cycle, LSB first.
- out_valid rises in cycle T0+NIBBLES+1. For NIBBLES=4, latency is 5 cycles from accept to out_valid.
- Throughput: at most one operation per NIBBLES+2 cycles with out_ready held high.
- The adder path is combinational within a RUN cycle: add_* out → add_sum/add_cout in → captured at that cycle's edge.
- out_valid stays high with stable data for any number of cycles while out_ready=0.

## Test plan
- in_a=0x1234, in_b=0x4321, in_cin=0 → out_sum=0x5555, cout=0, ovf=0. out_valid exactly 5 cycles after accept. add_enable=0 only in the 4 RUN cycles.
- 0xFFFF + 0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Carry ripples through all 4 nibbles: add_cin=1 in RUN cycles 2–4.
- 0x7FFF + 0x0001 → sum=0x8000, cout=0, ovf=1. 0x00FF + 0x0000 with cin=1 → sum=0x0100, cout=0.
- Hold out_ready=0 for 3 cycles in DONE, with in_valid=1 and different operands → out_valid held high, out_sum unchanged, in_ready=0, no new accept. The release cycle goes to IDLE, and the accept occurs the cycle after.
- Assert rst during the second RUN cycle of 0x1234+0x4321 → next cycle IDLE: out_valid=0, out_sum=0, add_enable=1, in_ready=1 after release. A fresh 0x0001+0x0001 then yields 0x0002.
